// File: rtl/song_sequencer.sv
// song_sequencer: plays a ROM of {dur, note} entries as timed note codes for a tone stage.
// Ports: clk, rst_n (async active-low); play (start pulse), pause (hold level), stop (abort pulse);
//        note_code[7:0], note_active, note_index[ADDR_W-1:0], busy, song_done (one-cycle pulse).
// Parameters: TICK_DIV clk cycles per tick, GAP_TICKS silent ticks per entry, ADDR_W ROM address width,
//             ROM_INIT song contents, entry i at bits [16*i +: 16] (all-zero default is an empty song).
// Macro SONG_LOOP_EN: end of song restarts at entry 0 instead of entering DONE.
module song_sequencer #(
    parameter int TICK_DIV = 1000000,
    parameter int GAP_TICKS = 2,
    parameter int ADDR_W = 6,
    parameter logic [(16<<ADDR_W)-1:0] ROM_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    output logic [7:0]        note_code,
    output logic              note_active,
    output logic [ADDR_W-1:0] note_index,
    output logic              busy,
    output logic              song_done
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] idx_n;
    logic [7:0] note_r, note_n, dur_r, dur_n, tick, tick_n, lim;
    logic [DIV_W-1:0] div, div_n;
    logic [15:0] rom_q;
    logic fph, fph_n, done_n, fin, play_q, act_r, paused;
    // play is registered so a start sampled at edge N yields a note after edge N+3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            note_index <= '0;
            note_r <= '0;
            dur_r <= '0;
            tick <= '0;
            div <= '0;
            fph <= 1'b0;
            song_done <= 1'b0;
            play_q <= 1'b0;
            act_r <= 1'b0;
            rom_q <= '0;
        end else begin
            state <= state_n;
            note_index <= idx_n;
            note_r <= note_n;
            dur_r <= dur_n;
            tick <= tick_n;
            div <= div_n;
            fph <= fph_n;
            song_done <= done_n;
            play_q <= play && !stop;
            act_r <= (state_n == PLAY) && (note_n != 8'd0);
            rom_q <= ROM_INIT[{note_index, 4'b0000} +: 16];
        end
    end
    always_comb begin
        state_n = state;
        idx_n = note_index;
        note_n = note_r;
        dur_n = dur_r;
        div_n = div;
        tick_n = tick;
        fph_n = fph;
        done_n = 1'b0;
        fin = 1'b0;
        lim = (state == GAP) ? 8'(GAP_TICKS - 1) : dur_r - 8'd1;
        unique case (state)
            IDLE, DONE: if (play_q) begin
                state_n = FETCH;
                idx_n = '0;
                fph_n = 1'b0;
            end
            // first cycle issues the address, second consumes the registered ROM word
            FETCH: begin
                fph_n = 1'b1;
                if (fph) begin
                    if (rom_q[15:8] != 8'd0) begin
                        state_n = PLAY;
                        note_n = rom_q[7:0];
                        dur_n = rom_q[15:8];
                        div_n = '0;
                        tick_n = '0;
                    end else fin = 1'b1;
                end
            end
            PLAY, GAP: if (!pause) begin
                if (div == DIV_MAX) begin
                    div_n = '0;
                    tick_n = tick + 8'd1;
                    if (tick == lim) begin
                        note_n = 8'd0;
                        if (state == PLAY && GAP_TICKS > 0) begin
                            state_n = GAP;
                            tick_n = '0;
                        end else if (note_index == {ADDR_W{1'b1}}) fin = 1'b1;
                        else begin
                            state_n = FETCH;
                            idx_n = note_index + ADDR_W'(1);
                            fph_n = 1'b0;
                        end
                    end
                end else div_n = div + DIV_W'(1);
            end
            default: ;
        endcase
        if (fin) begin
            done_n = 1'b1;
            note_n = 8'd0;
`ifdef SONG_LOOP_EN
            state_n = FETCH;
            idx_n = '0;
            fph_n = 1'b0;
`else
            state_n = DONE;
`endif
        end
        if (stop) begin
            state_n = IDLE;
            idx_n = '0;
            note_n = 8'd0;
            div_n = '0;
            tick_n = '0;
            fph_n = 1'b0;
            done_n = 1'b0;
        end
    end
    assign paused = pause && (state == PLAY || state == GAP);
    assign note_code = paused ? 8'd0 : note_r;
    assign note_active = act_r && !paused;
    assign busy = !(state == IDLE || state == DONE);
endmodule
